// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory responder for the MEM-stage
// load/store port. One request is in flight at a time. After acceptance it is
// held for WAIT_CYCLES wait states, committed on the edge that enters RESP,
// and answered with a one-cycle resp_valid strobe.
// Optional feature macro: DMEM_ERR_STICKY_EN adds err_clr / err_sticky.
//
// Handshake: the requester raises req_valid and holds every req_* field
// stable until it sees resp_valid. stall is high while the responder owns the
// request, which is the IDLE acceptance cycle plus every WAIT cycle. resp_valid
// marks the single cycle in which r_data and err belong to that request.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] r_data,
    output logic        err,
`ifdef DMEM_ERR_STICKY_EN
    input  logic        err_clr,
    output logic        err_sticky,
`endif
    output logic [1:0]  dbg_state
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_U = DEPTH_WORDS;
    localparam logic [3:0]  WAIT_U  = WAIT_CYCLES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] r_data_q, r_data_d;
    logic        err_q, err_d;

    // Storage is deliberately left out of reset; only the control path resets.
    logic [31:0] mem_q [DEPTH_WORDS];

    // The access that commits this edge. With zero wait states the commit
    // happens on the acceptance edge itself, so the live request fields are
    // used in IDLE and the captured copies everywhere else.
    logic          commit;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          mem_we;

    // Select the access fields and classify them (misaligned or out of range).
    always_comb begin
        acc_write = (state_q == S_IDLE) ? req_write : write_q;
        acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
        acc_be    = (state_q == S_IDLE) ? req_be    : be_q;
        acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH_U);
        acc_idx   = acc_addr[AW+1:2];
    end

    // Next-state logic, request capture, wait countdown and response data.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        commit       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = WAIT_U;
                    if (WAIT_U == 4'd0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The last wait state is the one where the counter reads 1.
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        resp_valid_d = commit;
        r_data_d     = r_data_q;
        err_d        = err_q;
        if (commit) begin
            err_d = acc_err;
            if (acc_err) begin
                r_data_d = 32'h0;
            end else if (!acc_write) begin
                r_data_d = mem_q[acc_idx];
            end
        end
        // A store abandoned by reset must never reach the array.
        mem_we = commit && acc_write && !acc_err && rst_n;
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            resp_valid_q <= 1'b0;
            r_data_q     <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_valid_q <= resp_valid_d;
            r_data_q     <= r_data_d;
            err_q        <= err_d;
        end
    end

    // Byte-enabled store into the array on the commit edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && acc_be[i]) begin
                mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ERR_STICKY_EN
    logic err_sticky_q, err_sticky_d;

    // Sticky error: an erroring RESP sets it and wins over a same-cycle clear.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if ((state_q == S_RESP) && err_q) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

    assign stall      = ((state_q == S_IDLE) && req_valid) || (state_q == S_WAIT);
    assign resp_valid = resp_valid_q;
    assign r_data     = r_data_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responders, one with two wait states and one
// with none, driven by directed tables, hand-written corner sequences and
// random traffic scored against a word-level memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: WAIT_CYCLES=2. Instance b: WAIT_CYCLES=0.
    logic        a_req_valid, a_req_write, a_stall, a_resp_valid, a_err;
    logic [31:0] a_req_addr, a_req_wdata, a_r_data;
    logic [3:0]  a_req_be;
    logic [1:0]  a_dbg;
    logic        b_req_valid, b_req_write, b_stall, b_resp_valid, b_err;
    logic [31:0] b_req_addr, b_req_wdata, b_r_data;
    logic [3:0]  b_req_be;
    logic [1:0]  b_dbg;
`ifdef DMEM_ERR_STICKY_EN
    logic a_err_clr = 1'b0, a_err_sticky, b_err_clr = 1'b0, b_err_sticky;
`endif

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_be(a_req_be),
        .stall(a_stall), .resp_valid(a_resp_valid), .r_data(a_r_data), .err(a_err),
`ifdef DMEM_ERR_STICKY_EN
        .err_clr(a_err_clr), .err_sticky(a_err_sticky),
`endif
        .dbg_state(a_dbg)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_be(b_req_be),
        .stall(b_stall), .resp_valid(b_resp_valid), .r_data(b_r_data), .err(b_err),
`ifdef DMEM_ERR_STICKY_EN
        .err_clr(b_err_clr), .err_sticky(b_err_sticky),
`endif
        .dbg_state(b_dbg)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input bit sel, input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        if (sel) begin
            b_req_valid = v; b_req_write = w; b_req_addr = a; b_req_wdata = d; b_req_be = be;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_addr = a; a_req_wdata = d; a_req_be = be;
        end
    endtask

    // Presents one request (caller is just after a negedge), counts stall
    // cycles until the response, then drops req_valid and moves one cycle on.
    task automatic do_access(input bit sel, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             output logic [31:0] rd, output logic e,
                             output int stalls, output int rcyc);
        bit got;
        logic s, rv;
        got = 0; stalls = 0; rd = 32'h0; e = 1'b0; rcyc = 0;
        set_req(sel, 1'b1, w, a, d, be);
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            s  = sel ? b_stall : a_stall;
            rv = sel ? b_resp_valid : a_resp_valid;
            if (rv) begin
                got  = 1;
                rd   = sel ? b_r_data : a_r_data;
                e    = sel ? b_err : a_err;
                rcyc = cyc;
                check("stall_in_resp", {31'b0, s}, 32'h0);
            end else begin
                if (s) stalls++;
                @(negedge clk);
            end
        end
        check("resp_arrived", {31'b0, got}, 32'h1);
        set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        rv = sel ? b_resp_valid : a_resp_valid;
        check("resp_one_cycle", {31'b0, rv}, 32'h0);
    endtask

    // Word-level model: errors from the address rules, byte merges for stores.
    // Words never fully written are unknown and their load data is not scored.
    task automatic model_access(input bit sel, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be,
                                output logic [31:0] exp_rd, output logic exp_err,
                                output bit chk_rd);
        int key;
        logic [31:0] tmp;
        exp_err = (a % 4 != 0) || ((a / 4) >= DEPTH);
        exp_rd  = 32'h0;
        chk_rd  = 0;
        key     = (sel ? 65536 : 0) + int'(a / 4);
        if (exp_err) begin
            chk_rd = 1;
        end else if (w) begin
            if (model_mem.exists(key)) begin
                tmp = model_mem[key];
                for (int i = 0; i < 4; i++) if (be[i]) tmp[8*i +: 8] = d[8*i +: 8];
                model_mem[key] = tmp;
            end else if (be == 4'hF) begin
                model_mem[key] = d;
            end
        end else if (model_mem.exists(key)) begin
            chk_rd = 1;
            exp_rd = model_mem[key];
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        chk_rd;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] rd, mrd;
        logic e, merr;
        bit mchk;
        int st, rc, rc1, rc2;
        logic [31:0] a, d;
        logic [3:0] be;
        logic w;
        bit sel;
        int kind;

        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_resp_valid", {31'b0, a_resp_valid}, 32'h0);
        check("rst_r_data", a_r_data, 32'h0);
        check("rst_err", {31'b0, a_err}, 32'h0);
        check("rst_stall", {31'b0, a_stall}, 32'h0);
        check("rst_b_resp_valid", {31'b0, b_resp_valid}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table on the two-wait-state instance.
        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'h5, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h13,       32'h0,        4'h0, 32'h0,        1'b1, 1'b1};
        vecs[5]  = '{1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1, 1'b1};
        vecs[6]  = '{1'b1, 32'h12,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1'b1};
        vecs[7]  = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0,        32'h0BADF00D, 4'hF, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1'b1};
        vecs[11] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h0BADF00D, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'hFFC,      32'h12345678, 4'hF, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'hFFC,      32'h0,        4'h0, 32'h12345678, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 32'hFFC,      32'hAABBCCDD, 4'hA, 32'h0,        1'b0, 1'b0};
        vecs[15] = '{1'b0, 32'hFFC,      32'h0,        4'h0, 32'hAA34CC78, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1};
        for (int i = 0; i < 17; i++) begin
            model_access(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, mrd, merr, mchk);
            do_access(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, rd, e, st, rc);
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_stalls", i), st, 32'd3);
        end

        // Reset during WAIT abandons a store.
        model_access(0, 1, 32'h20, 32'h55667788, 4'hF, mrd, merr, mchk);
        do_access(0, 1, 32'h20, 32'h55667788, 4'hF, rd, e, st, rc);
        do_access(0, 0, 32'h20, 32'h0, 4'h0, rd, e, st, rc);
        check("pre_reset_load", rd, 32'h55667788);
        set_req(0, 1, 1, 32'h20, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        #1;
        check("stall_in_wait", {31'b0, a_stall}, 32'h1);
        rst_n = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("resp_valid_in_reset", {31'b0, a_resp_valid}, 32'h0);
            @(negedge clk);
        end
        check("r_data_in_reset", a_r_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        do_access(0, 0, 32'h20, 32'h0, 4'h0, rd, e, st, rc);
        check("post_reset_load", rd, 32'h55667788);

`ifdef DMEM_ERR_STICKY_EN
        #1;
        check("sticky_after_reset", {31'b0, a_err_sticky}, 32'h0);
        do_access(0, 0, 32'h13, 32'h0, 4'h0, rd, e, st, rc);
        check("sticky_set", {31'b0, a_err_sticky}, 32'h1);
        do_access(0, 0, 32'h10, 32'h0, 4'h0, rd, e, st, rc);
        check("sticky_good_err", {31'b0, e}, 32'h0);
        check("sticky_persist", {31'b0, a_err_sticky}, 32'h1);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        #1;
        check("sticky_cleared", {31'b0, a_err_sticky}, 32'h0);
        a_err_clr = 1'b1;
        do_access(0, 0, 32'h13, 32'h0, 4'h0, rd, e, st, rc);
        check("sticky_set_wins", {31'b0, a_err_sticky}, 32'h1);
        a_err_clr = 1'b0;
`endif

        // Zero-wait instance: back-to-back loads.
        model_access(1, 1, 32'h0, 32'hA0A0A0A0, 4'hF, mrd, merr, mchk);
        do_access(1, 1, 32'h0, 32'hA0A0A0A0, 4'hF, rd, e, st, rc);
        model_access(1, 1, 32'h4, 32'hB1B1B1B1, 4'hF, mrd, merr, mchk);
        do_access(1, 1, 32'h4, 32'hB1B1B1B1, 4'hF, rd, e, st, rc);
        do_access(1, 0, 32'h0, 32'h0, 4'h0, rd, e, st, rc1);
        check("w0_load0_data", rd, 32'hA0A0A0A0);
        check("w0_load0_stalls", st, 32'd1);
        do_access(1, 0, 32'h4, 32'h0, 4'h0, rd, e, st, rc2);
        check("w0_load1_data", rd, 32'hB1B1B1B1);
        check("w0_load1_stalls", st, 32'd1);
        check("w0_resp_spacing", rc2 - rc1, 32'd2);

        // Random traffic: prefill a small window, then mixed accesses.
        for (int s = 0; s < 2; s++) begin
            for (int wd = 0; wd < 16; wd++) begin
                d = $urandom;
                model_access(s[0], 1, 32'(wd * 4), d, 4'hF, mrd, merr, mchk);
                do_access(s[0], 1, 32'(wd * 4), d, 4'hF, rd, e, st, rc);
            end
        end
        for (int n = 0; n < 150; n++) begin
            sel  = $urandom_range(0, 1) == 1;
            w    = $urandom_range(0, 1) == 1;
            kind = $urandom_range(0, 9);
            if (kind == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (kind == 1) a = 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
            else                a = 32'($urandom_range(0, 15) * 4);
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            model_access(sel, w, a, d, be, mrd, merr, mchk);
            exp_q.push_back(mrd);
            do_access(sel, w, a, d, be, rd, e, st, rc);
            mrd = exp_q.pop_front();
            check("rand_err", {31'b0, e}, {31'b0, merr});
            if (mchk) check("rand_rdata", rd, mrd);
            check("rand_stalls", st, sel ? 32'd1 : 32'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
